// File: rtl/sseg_display_if.sv
// sseg_display_if: value-in / segment-and-anode-out bundle for the seven-segment driver
// Signals: data (13-bit value to show), sseg (active-low {dp,g,f,e,d,c,b,a}), an (active-low anodes, an[0]=units)
interface sseg_display_if;
  logic [12:0] data;
  logic [7:0]  sseg;
  logic [3:0]  an;
  modport master (output data, input sseg, an);
  modport slave  (input data, output sseg, an);
endinterface

// File: rtl/sseg_display.sv
// sseg_display: 4-digit multiplexed common-anode seven-segment driver for a 13-bit binary value
// Ports: clk, reset (sync active-high), bus.slave (data in; sseg/an out, registered, active-low)
module sseg_display #(
  parameter int DIGIT_CYCLES  = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input logic     clk,
  input logic     reset,
  sseg_display_if.slave bus
);
  localparam int CW = DIGIT_CYCLES > 1 ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGIT_CYCLES - 1);

  // Max value 8191 keeps the thousands nibble at 8, so 16 bits never overflow.
  function automatic logic [15:0] dd(input logic [12:0] b);
    logic [15:0] r;
    r = '0;
    for (int i = 12; i >= 0; i--) begin
      for (int k = 0; k < 4; k++)
        if (r[4*k +: 4] > 4'd4) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
      r = {r[14:0], b[i]};
    end
    return r;
  endfunction

  function automatic logic [7:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 8'hC0;
      4'd1: seg = 8'hF9;
      4'd2: seg = 8'hA4;
      4'd3: seg = 8'hB0;
      4'd4: seg = 8'h99;
      4'd5: seg = 8'h92;
      4'd6: seg = 8'h82;
      4'd7: seg = 8'hF8;
      4'd8: seg = 8'h80;
      4'd9: seg = 8'h90;
      default: seg = 8'hFF;
    endcase
  endfunction

  logic [12:0]   data_q;
  logic [15:0]   bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    sseg_q, sseg_d;
  logic [3:0]    blank;
  logic          last;

  always_comb begin
    bcd_d  = dd(data_q);
    last   = cnt_q == LAST;
    cnt_d  = last ? '0 : cnt_q + 1'b1;
    idx_d  = last ? idx_q + 2'd1 : idx_q;
    // Digit k is blank when it and every more-significant digit are zero; units never blank.
    blank  = {bcd_q[15:12] == 4'd0, bcd_q[15:8] == 8'd0, bcd_q[15:4] == 12'd0, 1'b0};
    an_d   = ~(4'b0001 << idx_q);
    sseg_d = (BLANK_LEADING && blank[idx_q]) ? 8'hFF : seg(bcd_q[4*idx_q +: 4]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      an_q   <= 4'hF;
      sseg_q <= 8'hFF;
    end else begin
      data_q <= bus.data;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      an_q   <= an_d;
      sseg_q <= sseg_d;
    end
  end

  assign bus.an   = an_q;
  assign bus.sseg = sseg_q;
endmodule

// File: tb/tb_sseg_display.sv
// tb_sseg_display: directed self-checking bench for sseg_display (blanking and non-blanking instances)
module tb_sseg_display;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] data = '0;
  int          checks = 0;
  int          fails = 0;

  sseg_display_if a_if ();
  sseg_display_if b_if ();
  assign a_if.data = data;
  assign b_if.data = data;

  sseg_display #(.DIGIT_CYCLES(2), .BLANK_LEADING(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
  sseg_display #(.DIGIT_CYCLES(2), .BLANK_LEADING(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(b_if));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Records the segment byte seen on each anode over one full scan, packed {d3,d2,d1,d0}.
  task automatic capture(output logic [31:0] ga, output logic [31:0] gb, output int bad);
    bit fa, fb;
    ga = '0;
    gb = '0;
    bad = 0;
    for (int n = 0; n < 8; n++) begin
      tick();
      fa = 0;
      fb = 0;
      for (int k = 0; k < 4; k++) begin
        if (a_if.an == 4'(~(4'b0001 << k))) begin ga[8*k +: 8] = a_if.sseg; fa = 1; end
        if (b_if.an == 4'(~(4'b0001 << k))) begin gb[8*k +: 8] = b_if.sseg; fb = 1; end
      end
      if (!fa) bad++;
      if (!fb) bad++;
    end
  endtask

  task automatic test_reset;
    logic [3:0] ea [10] = '{4'b1110, 4'b1110, 4'b1101, 4'b1101, 4'b1011,
                            4'b1011, 4'b0111, 4'b0111, 4'b1110, 4'b1110};
    logic [7:0] es [10] = '{8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hFF,
                            8'hFF, 8'hFF, 8'hFF, 8'h99, 8'h99};
    data = 13'd4;
    reset = 1'b1;
    for (int r = 0; r < 2; r++) begin
      tick();
      checks++;
      if (a_if.an !== 4'b1111) begin fails++; $display("FAIL reset_an got %b want 1111", a_if.an); end
      checks++;
      if (a_if.sseg !== 8'hFF) begin fails++; $display("FAIL reset_sseg got %h want FF", a_if.sseg); end
    end
    reset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      checks++;
      if (a_if.an !== ea[n] || a_if.sseg !== es[n]) begin
        fails++;
        $display("FAIL scan_after_reset edge %0d got %b/%h want %b/%h", n + 1, a_if.an, a_if.sseg, ea[n], es[n]);
      end
    end
  endtask

  task automatic test_digits(input string nm, input logic [12:0] v, input logic [31:0] ea, input logic [31:0] eb);
    logic [31:0] ga, gb;
    int bad;
    data = v;
    repeat (3) tick();
    capture(ga, gb, bad);
    checks++;
    if (bad !== 0) begin fails++; $display("FAIL %s_onehot got %0d bad anode cycles want 0", nm, bad); end
    checks++;
    if (ga !== ea) begin fails++; $display("FAIL %s_blank got %h want %h", nm, ga, ea); end
    checks++;
    if (gb !== eb) begin fails++; $display("FAIL %s_noblank got %h want %h", nm, gb, eb); end
  endtask

  task automatic test_data_change;
    logic [3:0] ea [9] = '{4'b0111, 4'b1110, 4'b1110, 4'b1101, 4'b1101,
                           4'b1011, 4'b1011, 4'b0111, 4'b0111};
    logic [7:0] es [9] = '{8'hFF, 8'h99, 8'hF8, 8'hB0, 8'hB0,
                           8'hFF, 8'hFF, 8'hFF, 8'hFF};
    data = 13'd4;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (7) tick();
    data = 13'd37;
    for (int n = 0; n < 9; n++) begin
      tick();
      checks++;
      if (a_if.an !== ea[n] || a_if.sseg !== es[n]) begin
        fails++;
        $display("FAIL data_change edge %0d got %b/%h want %b/%h", n + 1, a_if.an, a_if.sseg, ea[n], es[n]);
      end
    end
  endtask

  task automatic test_reset_midscan;
    logic [3:0] ea [3] = '{4'b1110, 4'b1110, 4'b1101};
    logic [7:0] es [3] = '{8'hC0, 8'hC0, 8'hB0};
    data = 13'd37;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (a_if.an !== 4'b1011) begin fails++; $display("FAIL midscan_pre got %b want 1011", a_if.an); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (a_if.an !== 4'b1111 || a_if.sseg !== 8'hFF) begin
      fails++;
      $display("FAIL midscan_reset got %b/%h want 1111/FF", a_if.an, a_if.sseg);
    end
    for (int n = 0; n < 3; n++) begin
      tick();
      checks++;
      if (a_if.an !== ea[n] || a_if.sseg !== es[n]) begin
        fails++;
        $display("FAIL midscan_restart edge %0d got %b/%h want %b/%h", n + 1, a_if.an, a_if.sseg, ea[n], es[n]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_digits("v4",    13'd4,    32'hFFFFFF99, 32'hC0C0C099);
    test_digits("v8191", 13'd8191, 32'h80F990F9, 32'h80F990F9);
    test_digits("v1005", 13'd1005, 32'hF9C0C092, 32'hF9C0C092);
    test_digits("v0",    13'd0,    32'hFFFFFFC0, 32'hC0C0C0C0);
    test_digits("v37",   13'd37,   32'hFFFFB0F8, 32'hC0C0B0F8);
    test_digits("v6200", 13'd6200, 32'h82A4C0C0, 32'h82A4C0C0);
    test_data_change();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
